// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the digit-serial multiplier sequencer.
// Digits are 3 bits wide; counter width is derived from the digit count.
package mult_ctrl_pkg;

   localparam int DIGIT_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic int dig_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/digit_mul3x3.sv
// Combinational 3x3-bit unsigned digit multiplier.
// Produces a 6-bit partial product; no state.
module digit_mul3x3
   import mult_ctrl_pkg::*;
(
   input  logic [DIGIT_W-1:0]   x,
   input  logic [DIGIT_W-1:0]   y,
   output logic [2*DIGIT_W-1:0] p
);

   localparam int PW = 2 * DIGIT_W;

   assign p = PW'(x) * PW'(y);

endmodule

// File: rtl/digit_serial_mult_ctrl.sv
// Digit-serial WIDTH x WIDTH multiplier reusing one 3x3 digit multiplier.
// Optional MULT_ZERO_SKIP_EN: zero operands skip the digit loop.
module digit_serial_mult_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int NDIG = WIDTH / DIGIT_W;
   localparam int IW   = dig_idx_w(NDIG);
   localparam int PW   = 2 * WIDTH;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    i_q, i_d, j_q, j_d;
   logic             fin_q, fin_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    term_q, term_d;

   logic [DIGIT_W-1:0]   a_dig, b_dig;
   logic [2*DIGIT_W-1:0] pp;
   logic [PW-1:0]        pp_sh;
   logic                 skip;

   assign a_dig = a_q[DIGIT_W*int'(i_q) +: DIGIT_W];
   assign b_dig = b_q[DIGIT_W*int'(j_q) +: DIGIT_W];

   digit_mul3x3 u_mul (
      .x (a_dig),
      .y (b_dig),
      .p (pp)
   );

   assign pp_sh = PW'(pp) << (DIGIT_W * (int'(i_q) + int'(j_q)));

`ifdef MULT_ZERO_SKIP_EN
   assign skip = (a == '0) || (b == '0);
`else
   assign skip = 1'b0;
`endif

   // The shifted partial product is staged in term_q; fin_q marks that the
   // last term is staged, so one extra RUN cycle drains it into acc_q.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      i_d     = i_q;
      j_d     = j_q;
      fin_d   = fin_q;
      acc_d   = acc_q;
      term_d  = term_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               i_d     = '0;
               j_d     = '0;
               acc_d   = '0;
               term_d  = '0;
               fin_d   = skip;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = acc_q + term_q;
            if (fin_q) begin
               term_d  = '0;
               state_d = DONE;
            end else begin
               term_d = pp_sh;
               if (i_q == LAST) begin
                  i_d = '0;
                  if (j_q == LAST) fin_d = 1'b1;
                  else             j_d = j_q + 1'b1;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         fin_q   <= 1'b0;
         acc_q   <= '0;
         term_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         i_q     <= i_d;
         j_q     <= j_d;
         fin_q   <= fin_d;
         acc_q   <= acc_d;
         term_q  <= term_d;
      end
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign product   = out_valid ? acc_q : '0;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_digit_serial_mult_ctrl.sv
// Self-checking bench for digit_serial_mult_ctrl (WIDTH=12).
// Vector table, handshake corner cases, reset abort and random stream.
module tb_digit_serial_mult_ctrl;

   localparam int W = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          in_ready;
   logic          out_valid;
   logic          busy;
   logic [2*W-1:0] product;

   digit_serial_mult_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
      int             lat;
   } vec_t;

   vec_t           tv[8];
   logic [2*W-1:0] exp_q[$];
   int             n_vec = 0;
   int             n_err = 0;
   int             acc_cyc = 0;
   int             n_acc = 0;
   int             n_del = 0;
   int             zlat;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      a = x;
      b = y;
      for (int k = 0; k < 60; k++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back({12'd0, x} * {12'd0, y});
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic recv(input string nm, input int lat);
      bit ok;
      logic [2*W-1:0] e;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk({nm, "_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (lat >= 0) chk({nm, "_lat"}, 32'(cyc - acc_cyc), 32'(lat));
      if (exp_q.size() == 0) begin
         chk({nm, "_noexp"}, 32'd0, 32'd1);
         return;
      end
      e = exp_q.pop_front();
      chk(nm, 32'(product), 32'(e));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
`ifdef MULT_ZERO_SKIP_EN
      zlat = 1;
`else
      zlat = 17;
`endif
      tv[0] = '{12'd3329, 12'd3329, 24'hA91A01, 17};
      tv[1] = '{12'd4095, 12'd4095, 24'hFFE001, 17};
      tv[2] = '{12'd0,    12'd1234, 24'd0,      zlat};
      tv[3] = '{12'd1234, 12'd0,    24'd0,      zlat};
      tv[4] = '{12'd1,    12'd1,    24'd1,      17};
      tv[5] = '{12'd4095, 12'd1,    24'h000FFF, 17};
      tv[6] = '{12'd2048, 12'd2048, 24'h400000, 17};
      tv[7] = '{12'd4095, 12'd7,    24'd28665,  17};

      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      for (int v = 0; v < 8; v++) begin
         send(tv[v].a, tv[v].b);
         void'(exp_q.pop_back());
         exp_q.push_back(tv[v].p);
         recv($sformatf("vec%0d", v), tv[v].lat);
      end

      // out_ready held low in DONE with a competing request pending
      send(12'd17, 12'd2);
      for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
      in_valid = 1'b1;
      a = 12'd5;
      b = 12'd5;
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_product", 32'(product), 32'd34);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      void'(exp_q.pop_front());
      out_ready = 1'b1;
      chk("hs_cycle_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("after_hs_in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(24'd25);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
      recv("queued_5x5", 17);

      // reset mid-RUN
      send(12'd100, 12'd200);
      repeat (8) @(negedge clk);
      chk("run_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      repeat (2) @(negedge clk);
      chk("abort_hold_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      send(12'd100, 12'd200);
      recv("after_reset", 17);

      // random back-to-back stream with random out_ready
      fork
         begin
            for (int k = 0; k < 500; k++) begin
               bit ok;
               logic [W-1:0] x, y;
               ok = 1'b0;
               x = W'($urandom_range(0, 4095));
               y = W'($urandom_range(0, 4095));
               @(negedge clk);
               in_valid = 1'b1;
               a = x;
               b = y;
               for (int t = 0; t < 200; t++) begin
                  if (in_ready) begin
                     ok = 1'b1;
                     break;
                  end
                  @(negedge clk);
               end
               if (!ok) begin
                  chk("rnd_accept_timeout", 32'd0, 32'd1);
                  break;
               end
               exp_q.push_back({12'd0, x} * {12'd0, y});
               n_acc++;
               @(posedge clk);
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            for (int t = 0; t < 30000 && n_del < 500; t++) begin
               @(negedge clk);
               out_ready = 1'($urandom_range(0, 1));
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     chk("rnd_noexp", 32'd0, 32'd1);
                  end else begin
                     chk("rnd_product", 32'(product), 32'(exp_q.pop_front()));
                  end
                  n_del++;
               end
            end
            @(negedge clk);
            out_ready = 1'b0;
         end
      join
      chk("rnd_accepted", 32'(n_acc), 32'd500);
      chk("rnd_acc_eq_del", 32'(n_del), 32'(n_acc));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
